memc_req: RTL and testbench

- Requester-side front end for the memory controller, in the same clock domain.
- Accepts single-beat read/write requests from a CPU-side client over a valid/ready handshake.
- Drives the memory controller's strobe, address and write-data inputs, and obeys its busy flag (busy during reset and self-test).
- Returns one response per request over a valid/ready handshake; a watchdog flags a controller that never leaves busy after reset.

---
 rtl/memc_pkg.sv | 31 +++
 rtl/memc_req_wdog.sv | 30 +++
 rtl/memc_req.sv | 160 ++++++++++++++++
 tb/tb_memc_req.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memc_pkg.sv
// Shared definitions for the memory-controller requester front end and the
// controller it talks to.
package memc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 16;

  localparam int unsigned ST_WAIT_RDY  = 0;
  localparam int unsigned ST_IDLE      = 1;
  localparam int unsigned ST_WRITE     = 2;
  localparam int unsigned ST_READ      = 3;
  localparam int unsigned ST_READ_WAIT = 4;
  localparam int unsigned ST_RESPOND   = 5;
  localparam int unsigned ST_ERROR     = 6;
  localparam int unsigned ST_NUM       = 7;

  // One-hot encoding built from the shared state indices.
  typedef enum logic [ST_NUM-1:0] {
    WAIT_RDY  = 7'b1 << ST_WAIT_RDY,
    IDLE      = 7'b1 << ST_IDLE,
    WRITE     = 7'b1 << ST_WRITE,
    READ      = 7'b1 << ST_READ,
    READ_WAIT = 7'b1 << ST_READ_WAIT,
    RESPOND   = 7'b1 << ST_RESPOND,
    ERROR     = 7'b1 << ST_ERROR
  } state_e;

  localparam logic [7:0] WR_PATT_A = 8'hA5;
  localparam logic [7:0] WR_PATT_B = 8'h5A;

endpackage

// File: rtl/memc_req_wdog.sv
// Saturating busy-timeout counter; expired once LIMIT-1 counts have elapsed.
module memc_req_wdog #(
  parameter int unsigned LIMIT = 300000
) (
  input  logic clk,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expired = (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/memc_req.sv
// Requester front end: single-beat read/write requests in, controller strobes
// out, one response per request back to the client.
module memc_req
  import memc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned BUSY_TIMEOUT = 300000
) (
  input  logic                  memc_clk,
  input  logic                  memc_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  memc_rd_enable,
  output logic                  memc_wr_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_wr_data,
  input  logic [DATA_WIDTH-1:0] memc_rd_data,
  input  logic                  memc_busy,
  output logic                  init_error
);

  state_e                state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  init_err_q, init_err_d;
  logic                  wdog_count_en;
  logic                  wdog_expired;

  assign wdog_count_en = (state_q == WAIT_RDY) && memc_busy;

  memc_req_wdog #(
    .LIMIT(BUSY_TIMEOUT)
  ) u_wdog (
    .clk      (memc_clk),
    .clear    (memc_reset),
    .count_en (wdog_count_en),
    .expired  (wdog_expired)
  );

  assign req_ready = (state_q == IDLE) && !memc_busy;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    init_err_d  = init_err_q;
    unique case (state_q)
      WAIT_RDY: begin
        if (!memc_busy) begin
          state_d = IDLE;
        end else if (wdog_expired) begin
          state_d    = ERROR;
          init_err_d = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rsp_we_d = req_we;
          if (req_we) begin
            state_d = WRITE;
            wr_en_d = 1'b1;
          end else begin
            state_d = READ;
            rd_en_d = 1'b1;
          end
        end
      end
      WRITE: begin
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = RESPOND;
      end
      READ: begin
        lat_d   = 4'(RD_LATENCY - 1);
        state_d = READ_WAIT;
      end
      // Sample lands RD_LATENCY edges after the strobe drops.
      READ_WAIT: begin
        if (lat_q == 4'd0) begin
          rsp_rdata_d = memc_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      ERROR: begin
        init_err_d = 1'b1;
      end
      default: begin
        state_d = WAIT_RDY;
      end
    endcase
  end

  always_ff @(posedge memc_clk) begin
    if (memc_reset) begin
      state_q     <= WAIT_RDY;
      lat_q       <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_err_q  <= init_err_d;
    end
  end

  assign memc_rd_enable = rd_en_q;
  assign memc_wr_enable = wr_en_q;
  assign memc_addr      = addr_q;
  assign memc_wr_data   = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_we         = rsp_we_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign init_error     = init_err_q;

endmodule

// File: tb/tb_memc_req.sv
// Scoreboard bench for memc_req: instance 0 uses RD_LATENCY=1, instance 1 uses
// RD_LATENCY=3 with a short busy timeout.
module tb_memc_req;
  import memc_pkg::*;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  typedef struct {
    int unsigned inst;
    logic        we;
    logic [7:0]  rdata;
    int unsigned at;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_we    [2];
  logic [7:0]  rsp_rdata [2];
  logic        rd_en     [2];
  logic        wr_en     [2];
  logic [15:0] maddr     [2];
  logic [7:0]  mwdata    [2];
  logic [7:0]  rd_data   [2];
  logic        busy      [2];
  logic        init_err  [2];

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t        sbq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memc_req #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(LAT0), .BUSY_TIMEOUT(300000)) u_dut0 (
    .memc_clk(clk), .memc_reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]), .rsp_rdata(rsp_rdata[0]),
    .memc_rd_enable(rd_en[0]), .memc_wr_enable(wr_en[0]), .memc_addr(maddr[0]),
    .memc_wr_data(mwdata[0]), .memc_rd_data(rd_data[0]), .memc_busy(busy[0]),
    .init_error(init_err[0])
  );

  memc_req #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(LAT1), .BUSY_TIMEOUT(50)) u_dut1 (
    .memc_clk(clk), .memc_reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]), .rsp_rdata(rsp_rdata[1]),
    .memc_rd_enable(rd_en[1]), .memc_wr_enable(wr_en[1]), .memc_addr(maddr[1]),
    .memc_wr_data(mwdata[1]), .memc_rd_data(rd_data[1]), .memc_busy(busy[1]),
    .init_error(init_err[1])
  );

  function automatic logic [7:0] mdata(input logic [15:0] a);
    return a[7:0] ^ WR_PATT_A;
  endfunction

  // Controller read model: data is valid only in the cycle before the sample edge.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int unsigned L = (g == 0) ? LAT0 : LAT1;
    bit [15:0] vpipe;
    always @(posedge clk) vpipe <= {vpipe[14:0], rd_en[g]};
    assign rd_data[g] = vpipe[L-1] ? mdata(maddr[g]) : 8'hEE;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  function automatic logic [63:0] outs(input int i);
    return 64'({rsp_valid[i], rsp_we[i], rsp_rdata[i], rd_en[i], wr_en[i],
                maddr[i], mwdata[i], init_err[i], req_ready[i]});
  endfunction

  // Monitor: every rising rsp_valid pops one expected response.
  initial begin
    bit   prev_v [2];
    exp_t e;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && !prev_v[i]) begin
          if (sbq.size() == 0 || sbq[0].inst != i) begin
            fail($sformatf("rsp%0d_unexpected", i), "response with none outstanding");
          end else begin
            e = sbq.pop_front();
            chk($sformatf("rsp%0d_we", i), rsp_we[i], e.we);
            chk($sformatf("rsp%0d_rdata", i), rsp_rdata[i], e.rdata);
            chk($sformatf("rsp%0d_cycle", i), cyc, e.at);
          end
        end
        prev_v[i] = rsp_valid[i];
      end
    end
  end

  task automatic issue(input int i, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input int unsigned lat, input bit expect_rsp);
    int unsigned n;
    int unsigned e0;
    exp_t        e;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready[i]) begin
      req_valid[i] = 1'b0;
      fail($sformatf("accept%0d_timeout", i), "req_ready never rose");
      return;
    end
    e0 = cyc + 1;
    if (expect_rsp) begin
      e.inst  = i;
      e.we    = we;
      e.rdata = we ? 8'h00 : mdata(addr);
      e.at    = we ? e0 + 1 : e0 + 1 + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk($sformatf("strobe%0d_on", i), {rd_en[i], wr_en[i]}, we ? 2'b01 : 2'b10);
    chk($sformatf("memc_addr%0d", i), maddr[i], addr);
    chk($sformatf("memc_wr_data%0d", i), mwdata[i], wd);
    @(negedge clk);
    chk($sformatf("strobe%0d_off", i), {rd_en[i], wr_en[i]}, 2'b00);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      fail("drain_timeout", "expected response never arrived");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned bad;
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b1;
    end
    busy[0] = 1'b1;
    busy[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs0", outs(0), 64'h0);
    chk("reset_outputs1", outs(1), 64'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready[0] || init_err[0]) bad++;
    end
    chk("busy_hold_ready_low", bad, 0);
    busy[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", req_ready[0], 1'b1);
    chk("no_init_error", init_err[0], 1'b0);

    issue(0, 1'b1, 16'h1234, WR_PATT_A, LAT0, 1'b1);
    drain();
    issue(0, 1'b0, 16'h00FF, 8'h00, LAT0, 1'b1);
    drain();

    busy[0]      = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0BEE;
    req_wdata[0] = 8'h3C;
    req_valid[0] = 1'b1;
    #1;
    chk("idle_busy_ready", req_ready[0], 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en[0] || rd_en[0] || req_ready[0]) bad++;
    end
    chk("idle_busy_no_accept", bad, 0);
    busy[0] = 1'b0;
    issue(0, 1'b1, 16'h0BEE, 8'h3C, LAT0, 1'b1);
    drain();

    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 16'h0042, 8'h00, LAT0, 1'b1);
    @(negedge clk);
    bad = 0;
    repeat (5) begin
      if (!rsp_valid[0] || rsp_rdata[0] != 8'hE7 || rsp_we[0] || req_ready[0]) bad++;
      @(negedge clk);
    end
    chk("rsp_hold_stable", bad, 0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("rsp_released_valid", rsp_valid[0], 1'b0);
    chk("rsp_released_ready", req_ready[0], 1'b1);

    rst[1]  = 1'b1;
    busy[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 49) chk("wdog_before_limit", init_err[1], 1'b0);
      if (k == 50) chk("wdog_at_limit", init_err[1], 1'b1);
    end
    busy[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("error_sticky", init_err[1], 1'b1);
    chk("error_ready_low", req_ready[1], 1'b0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("error_reset_outputs", outs(1), 64'h0);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("error_reset_ready", req_ready[1], 1'b1);

    issue(1, 1'b0, 16'h00FF, 8'h00, LAT1, 1'b1);
    drain();

    issue(1, 1'b0, 16'h0042, 8'h00, LAT1, 1'b0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("midread_reset_outputs", outs(1), 64'h0);
    rst[1] = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) bad++;
    end
    chk("midread_no_rsp", bad, 0);
    issue(1, 1'b0, 16'h00FF, 8'h00, LAT1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
